uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART receiver. Captures each single-cycle
//  uart_rx_valid pulse (data + break flag) into a DEPTH-entry synchronous FIFO.
//  Presents bytes to the consumer over a valid/ready stream.
//  Reports fill level, almost-full and a sticky overrun flag.
// PARAMETERS
//  PAYLOAD_BITS  8   width of one received character; must match the receiver
//  DEPTH         16  FIFO entries; power of two, >= 2
//  ALMOST_FULL   12  almost_full asserts when level >= this value; 1..DEPTH
// PORTS
//  clk            in   1                 system clock; all logic on posedge
//  reset          in   1                 synchronous, active-high reset
//  uart_rx_valid  in   1                 1-cycle pulse: a character was received
//  uart_rx_data   in   PAYLOAD_BITS      received character, valid with uart_rx_valid
//  uart_rx_break  in   1                 character is a BREAK, valid with uart_rx_valid
//  m_valid        out  1                 head entry available
//  m_ready        in   1                 consumer accepts head entry
//  m_data         out  PAYLOAD_BITS      head entry data
//  m_break        out  1                 head entry is a BREAK (see CONFIGURATION)
//  level          out  $clog2(DEPTH)+1   current number of stored entries, 0..DEPTH
//  almost_full    out  1                 level >= ALMOST_FULL
//  overrun        out  1                 sticky: a character was dropped because the FIFO was full
//  overrun_clr    in   1                 clears overrun
// BEHAVIOUR
//  - Reset (clk edge with reset=1): write/read pointers=0, level=0, overrun=0.
//    Resulting outputs: m_valid=0, m_data=0, m_break=0, almost_full=0.
//    Storage array is not reset. Reset mid-stream discards all contents and any same-cycle push/pop.
//  - push = uart_rx_valid. pop = m_valid & m_ready. Both are evaluated on the same clk edge.
//  - Write: on push, store {break,data} at wr_ptr, wr_ptr+1 (wraps mod DEPTH), level+1.
//  - Read: on pop, rd_ptr+1 (wraps mod DEPTH), level-1.
//  - Latency: a push at edge k makes m_valid=1 after edge k (first-word fall-through).
//    m_data/m_break reflect the new head in that same cycle.
//  - m_valid = (level != 0). m_data and m_break are forced to 0 when m_valid=0.
//    Otherwise they equal the head entry.
//  - m_data/m_break must stay stable while m_valid=1 and m_ready=0.
//  - Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
//  - Empty (level=0): pop cannot occur; a push proceeds normally.
//  - Full (level=DEPTH), push without pop: character dropped, pointers and level unchanged,
//    overrun set to 1 on that edge.
//  - Full, push with pop on the same edge: push is accepted and level stays DEPTH; no overrun.
//  - overrun: set by a drop and cleared by overrun_clr. If both occur on the same edge,
//    the set wins (overrun=1).
//  - almost_full and level are registered-state derived; they update on the edge after the event.
//  - Pointer arithmetic uses $clog2(DEPTH) bits with natural wrap.
//    level is computed separately, never from pointer difference.
// CONFIGURATION
//  UART_RX_FIFO_BREAK_EN defined:
//    - Entries are PAYLOAD_BITS+1 wide; uart_rx_break is stored per entry.
//    - m_break is driven from the head entry.
//  UART_RX_FIFO_BREAK_EN undefined:
//    - Entries are PAYLOAD_BITS wide; m_break is tied to 0.
//    - Characters with uart_rx_break=1 are discarded and never written.
//      They do not change level and do not set overrun, even when the FIFO is full.
// TESTING
//  1. Reset, then 3 pushes 0x41,0x42,0x43 with m_ready=0.
//     -> level=3, m_valid=1, m_data=0x41, held stable.
//     Then m_ready=1 -> 0x41,0x42,0x43 on consecutive cycles, then m_valid=0, m_data=0.
//  2. Push 16 bytes 0x00..0x0F with m_ready=0.
//     -> almost_full=1 from level 12, level=16.
//     17th push 0xAA -> dropped, overrun=1, level=16.
//     Drain -> 0x00..0x0F in order, no 0xAA.
//  3. Full FIFO, push 0x55 together with pop.
//     -> level stays 16, overrun stays 0, 0x55 is the last byte drained.
//  4. overrun=1, assert overrun_clr alone -> overrun=0 next cycle.
//     Assert overrun_clr on the same edge as a drop -> overrun=1.
//  5. Push data=0x00 with break=1, then 0x31 with break=0.
//     BREAK_EN defined: m_break=1 with m_data=0x00, then m_break=0 with 0x31.
//     BREAK_EN undefined: only 0x31 is delivered, level peaks at 1.
//  6. Load 5 entries, assert reset for 1 cycle while pushing and popping.
//     -> level=0, m_valid=0, overrun=0 after the edge.
//     A subsequent push of 0x7E is delivered as the sole entry.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and its consumer.
// Optional BREAK storage: define UART_RX_FIFO_BREAK_EN.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   uart_rx_valid      1-cycle pulse, character received
//   uart_rx_data       received character
//   uart_rx_break      character is a BREAK
//   m_valid/m_ready    output stream handshake
//   m_data, m_break    head entry (zero when m_valid=0)
//   level              stored entries, 0..DEPTH
//   almost_full        level >= ALMOST_FULL
//   overrun            sticky drop flag
//   overrun_clr        clears overrun (a same-edge drop wins)
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0]   uart_rx_data,
  input  logic                      uart_rx_break,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [PAYLOAD_BITS-1:0]   m_data,
  output logic                      m_break,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      almost_full,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef UART_RX_FIFO_BREAK_EN
  localparam int EW = PAYLOAD_BITS + 1;
`else
  localparam int EW = PAYLOAD_BITS;
`endif

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;

  logic          w_push_req;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic          w_drop;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_head;

`ifdef UART_RX_FIFO_BREAK_EN
  assign w_push_req = uart_rx_valid;
  assign w_wdata    = {uart_rx_break, uart_rx_data};
`else
  // BREAK characters are never stored in this build
  assign w_push_req = uart_rx_valid & ~uart_rx_break;
  assign w_wdata    = uart_rx_data;
`endif

  assign m_valid = (r_level != '0);
  assign w_pop   = m_valid & m_ready;
  assign w_full  = (r_level == LW'(DEPTH));
  // a pop on the same edge frees the slot for a push at full
  assign w_wr    = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign m_data      = m_valid ? w_head[PAYLOAD_BITS-1:0] : '0;
`ifdef UART_RX_FIFO_BREAK_EN
  assign m_break     = m_valid & w_head[PAYLOAD_BITS];
`else
  assign m_break     = 1'b0;
`endif
  assign level       = r_level;
  assign almost_full = (r_level >= LW'(ALMOST_FULL));
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table and sequence checks
// for uart_rx_fifo (DEPTH=16, ALMOST_FULL=12).
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_break;
  logic [4:0] level;
  logic       almost_full;
  logic       overrun;
  logic       overrun_clr;

  int checks;
  int failures;

  uart_rx_fifo #(
    .PAYLOAD_BITS(8),
    .DEPTH(16),
    .ALMOST_FULL(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx_valid(rx_valid),
    .uart_rx_data(rx_data),
    .uart_rx_break(rx_break),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_break(m_break),
    .level(level),
    .almost_full(almost_full),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       brk;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic [4:0] el;
    logic       ea;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input logic rst, input logic vld,
                      input logic [7:0] din, input logic brk,
                      input logic rdy, input logic clr);
    reset       = rst;
    rx_valid    = vld;
    rx_data     = din;
    rx_break    = brk;
    m_ready     = rdy;
    overrun_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic ev,
                     input logic [7:0] ed, input logic eb,
                     input logic [4:0] el, input logic ea,
                     input logic eo);
    checks++;
    if (m_valid !== ev || m_data !== ed || m_break !== eb ||
        level !== el || almost_full !== ea || overrun !== eo) begin
      failures++;
      $display("FAIL %s: got v=%b d=%h b=%b l=%0d af=%b ov=%b exp v=%b d=%h b=%b l=%0d af=%b ov=%b",
               nm, m_valid, m_data, m_break, level, almost_full,
               overrun, ev, ed, eb, el, ea, eo);
    end
  endtask

  task automatic add(input logic rst, input logic vld,
                     input logic [7:0] din, input logic brk,
                     input logic rdy, input logic clr,
                     input logic ev, input logic [7:0] ed,
                     input logic eb, input logic [4:0] el,
                     input logic ea, input logic eo);
    vec_t v;
    v.rst = rst; v.vld = vld; v.din = din; v.brk = brk;
    v.rdy = rdy; v.clr = clr; v.ev = ev; v.ed = ed;
    v.eb = eb; v.el = el; v.ea = ea; v.eo = eo;
    tbl.push_back(v);
  endtask

  initial begin
    logic [4:0] el;
    logic [7:0] ed;
    checks   = 0;
    failures = 0;

    // rst vld din brk rdy clr | ev ed eb el ea eo
    add(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h41, 0, 0, 0, 1, 8'h41, 0, 1, 0, 0);
    add(0, 1, 8'h42, 0, 0, 0, 1, 8'h41, 0, 2, 0, 0);
    add(0, 1, 8'h43, 0, 0, 0, 1, 8'h41, 0, 3, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1, 8'h41, 0, 3, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1, 8'h41, 0, 3, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 1, 8'h42, 0, 2, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 1, 8'h43, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
`ifdef UART_RX_FIFO_BREAK_EN
    add(0, 1, 8'h00, 1, 0, 0, 1, 8'h00, 1, 1, 0, 0);
    add(0, 1, 8'h31, 0, 0, 0, 1, 8'h00, 1, 2, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 1, 8'h31, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
`else
    add(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h31, 0, 0, 0, 1, 8'h31, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
`endif

    step(1, 0, 8'h00, 0, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].brk,
           tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed,
          tbl[i].eb, tbl[i].el, tbl[i].ea, tbl[i].eo);
    end

    // fill to 16, almost_full from level 12
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i), 0, 0, 0);
      el = 5'(i + 1);
      chk($sformatf("fill%0d", i), 1, 8'h00, 0, el,
          (i + 1) >= 12, 0);
    end
    step(0, 1, 8'hAA, 0, 0, 0);
    chk("drop", 1, 8'h00, 0, 5'd16, 1, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 0, 1, 0);
      el = 5'(15 - i);
      ed = (i < 15) ? 8'(i + 1) : 8'h00;
      chk($sformatf("drain%0d", i), i < 15, ed, 0, el,
          (15 - i) >= 12, 1);
    end

    step(0, 0, 8'h00, 0, 0, 1);
    chk("clr_alone", 0, 8'h00, 0, 5'd0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i), 0, 0, 0);
    end
    chk("refill", 1, 8'h00, 0, 5'd16, 1, 0);
    step(0, 1, 8'h55, 0, 1, 0);
    chk("full_push_pop", 1, 8'h01, 0, 5'd16, 1, 0);
`ifndef UART_RX_FIFO_BREAK_EN
    step(0, 1, 8'h99, 1, 0, 0);
    chk("full_break", 1, 8'h01, 0, 5'd16, 1, 0);
`endif
    step(0, 1, 8'hAA, 0, 0, 1);
    chk("clr_vs_drop", 1, 8'h01, 0, 5'd16, 1, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 0, 1, 0);
      el = 5'(15 - i);
      if (i < 14) ed = 8'(i + 2);
      else if (i == 14) ed = 8'h55;
      else ed = 8'h00;
      chk($sformatf("drain2_%0d", i), i < 15, ed, 0, el,
          (15 - i) >= 12, 1);
    end

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'(8'h60 + i), 0, 0, 0);
    end
    chk("load5", 1, 8'h60, 0, 5'd5, 0, 1);
    step(1, 1, 8'h66, 0, 1, 0);
    chk("mid_reset", 0, 8'h00, 0, 5'd0, 0, 0);
    step(0, 1, 8'h7E, 0, 0, 0);
    chk("after_reset", 1, 8'h7E, 0, 5'd1, 0, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("sole_entry", 0, 8'h00, 0, 5'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
